uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo_if.sv | 26 ++
 rtl/uart_tx_fifo.sv | 98 +++++++++
 tb/tb_uart_tx_fifo.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_if.sv
// Byte-stream handshake between a producer and the UART transmit FIFO.
// The master side enqueues bytes; the slave side (the FIFO) reports occupancy and drives the transmitter strobe.
interface uart_tx_fifo_if #(
    parameter int DEPTH = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [7:0]    wr_d;
    logic          wr_en;
    logic [7:0]    tx_d;
    logic          tx_rdy;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    logic          overflow;

    modport master (
        output wr_d, wr_en,
        input  tx_d, tx_rdy, full, empty, count, overflow
    );

    modport slave (
        input  wr_d, wr_en,
        output tx_d, tx_rdy, full, empty, count, overflow
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Circular-buffer FIFO that paces bytes out to a UART transmitter,
// issuing one tx_rdy strobe every GAP_CLKS cycles while data is queued.
module uart_tx_fifo #(
    parameter int DEPTH    = 16,
    parameter int GAP_CLKS = 10900
) (
    input  logic           clk,
    input  logic           rst,
    uart_tx_fifo_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int GW = $clog2(GAP_CLKS);

    typedef enum logic [1:0] {IDLE, LOAD, STROBE, WAIT} state_t;

    state_t        state;
    state_t        next_state;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_next;
    logic          full_q;
    logic          empty_q;
    logic          overflow_q;
    logic [7:0]    tx_d_q;
    logic [GW-1:0] gap_cnt;
    logic          do_wr;
    logic          do_pop;
    logic          tx_rdy_c;

    // Full is taken from registered state, so a write racing a pop on a full FIFO is still dropped.
    assign do_wr      = bus.wr_en && !full_q;
    assign count_next = count_q + CW'(do_wr) - CW'(do_pop);

    always_comb begin
        next_state = state;
        do_pop     = 1'b0;
        tx_rdy_c   = 1'b0;
        case (state)
            IDLE: begin
                if (!empty_q) begin
                    next_state = LOAD;
                    do_pop     = 1'b1;
                end
            end
            LOAD:   next_state = STROBE;
            STROBE: begin
                tx_rdy_c   = 1'b1;
                next_state = WAIT;
            end
            WAIT: begin
                if (gap_cnt == '0) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
            tx_d_q     <= '0;
            gap_cnt    <= '0;
        end else begin
            state      <= next_state;
            count_q    <= count_next;
            full_q     <= (count_next == CW'(DEPTH));
            empty_q    <= (count_next == '0);
            overflow_q <= bus.wr_en && full_q;
            if (do_wr) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop) begin
                tx_d_q <= mem[rd_ptr];
                rd_ptr <= rd_ptr + AW'(1);
            end
            // STROBE, WAIT, IDLE and LOAD together span exactly GAP_CLKS cycles.
            if (state == STROBE) gap_cnt <= GW'(GAP_CLKS - 4);
            else if (state == WAIT && gap_cnt != '0) gap_cnt <= gap_cnt - GW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && do_wr) mem[wr_ptr] <= bus.wr_d;
    end

    assign bus.tx_d     = tx_d_q;
    assign bus.tx_rdy   = tx_rdy_c;
    assign bus.full     = full_q;
    assign bus.empty    = empty_q;
    assign bus.count    = count_q;
    assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo at DEPTH=4, GAP_CLKS=8: a cycle table of
// hand-computed outputs followed by wrap-around bursts watched by a pacing monitor.
module tb_uart_tx_fifo;
    localparam int DEPTH = 4;
    localparam int GAP   = 8;

    typedef struct {
        logic       rst;
        logic       wr_en;
        logic [7:0] wr_d;
        int         reps;
        logic [7:0] e_tx_d;
        logic       e_rdy;
        logic       e_full;
        logic       e_empty;
        logic [2:0] e_count;
        logic       e_ovf;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    vec_t vecs[$];

    logic       mon_on = 1'b0;
    int         mon_idx;
    int         mon_cyc;
    int         mon_last;
    logic [7:0] mon_base;

    uart_tx_fifo_if #(.DEPTH(DEPTH)) bus ();

    uart_tx_fifo #(.DEPTH(DEPTH), .GAP_CLKS(GAP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic w, input logic [7:0] d, input int n,
                                input logic [7:0] td, input logic rdy, input logic f,
                                input logic e, input logic [2:0] c, input logic o);
        vec_t v;
        v.rst = r; v.wr_en = w; v.wr_d = d; v.reps = n;
        v.e_tx_d = td; v.e_rdy = rdy; v.e_full = f; v.e_empty = e; v.e_count = c; v.e_ovf = o;
        return v;
    endfunction

    task automatic apply_stimulus(input logic r, input logic w, input logic [7:0] d);
        rst        = r;
        bus.wr_en  = w;
        bus.wr_d   = d;
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input int row, input int rep, input vec_t v);
        checks++;
        if (bus.tx_d !== v.e_tx_d || bus.tx_rdy !== v.e_rdy || bus.full !== v.e_full ||
            bus.empty !== v.e_empty || bus.count !== v.e_count || bus.overflow !== v.e_ovf) begin
            errors++;
            $display("[TB] FAIL vec%0d.%0d: got tx_d=%h rdy=%b full=%b empty=%b count=%0d ovf=%b, want tx_d=%h rdy=%b full=%b empty=%b count=%0d ovf=%b",
                     row, rep, bus.tx_d, bus.tx_rdy, bus.full, bus.empty, bus.count, bus.overflow,
                     v.e_tx_d, v.e_rdy, v.e_full, v.e_empty, v.e_count, v.e_ovf);
        end
    endtask

    // Checks burst ordering, exact tx_rdy spacing and the occupancy ceiling every cycle.
    always @(negedge clk) begin
        if (mon_on) begin
            mon_cyc++;
            checks++;
            if (bus.count > 3'd4) begin
                errors++;
                $display("[TB] FAIL count_ceiling: got %0d, want <= 4", bus.count);
            end
            if (bus.tx_rdy) begin
                checks++;
                if (mon_idx >= 4 || bus.tx_d !== mon_base + 8'(mon_idx)) begin
                    errors++;
                    $display("[TB] FAIL burst_byte%0d: got %h, want %h", mon_idx, bus.tx_d, mon_base + 8'(mon_idx));
                end
                if (mon_idx > 0) begin
                    checks++;
                    if (mon_cyc - mon_last != GAP) begin
                        errors++;
                        $display("[TB] FAIL rdy_gap: got %0d, want %0d", mon_cyc - mon_last, GAP);
                    end
                end
                mon_last = mon_cyc;
                mon_idx++;
            end
        end
    end

    initial begin
        bus.wr_en = 1'b0;
        bus.wr_d  = '0;

        // Single byte latency, then three back-to-back bytes.
        vecs.push_back(mk(1, 0, 8'h00, 1, 8'h00, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 8'h41, 1, 8'h00, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 8'h41, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 8'h41, 1, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 7, 8'h41, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 8'h61, 1, 8'h41, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 8'h62, 1, 8'h61, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 8'h63, 1, 8'h61, 1, 0, 0, 2, 0));
        vecs.push_back(mk(0, 0, 8'h00, 6, 8'h61, 0, 0, 0, 2, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 8'h62, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 8'h62, 1, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 8'h00, 6, 8'h62, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 8'h63, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 8'h63, 1, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 6, 8'h63, 0, 0, 1, 0, 0));
        // Six consecutive writes: the sixth overflows; a write racing the pop from full is dropped too.
        vecs.push_back(mk(0, 1, 8'h01, 1, 8'h63, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 8'h02, 1, 8'h01, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 8'h03, 1, 8'h01, 1, 0, 0, 2, 0));
        vecs.push_back(mk(0, 1, 8'h04, 1, 8'h01, 0, 0, 0, 3, 0));
        vecs.push_back(mk(0, 1, 8'h05, 1, 8'h01, 0, 1, 0, 4, 0));
        vecs.push_back(mk(0, 1, 8'h06, 1, 8'h01, 0, 1, 0, 4, 1));
        vecs.push_back(mk(0, 0, 8'h00, 3, 8'h01, 0, 1, 0, 4, 0));
        vecs.push_back(mk(0, 1, 8'hAA, 1, 8'h02, 0, 0, 0, 3, 1));
        vecs.push_back(mk(0, 0, 8'h00, 1, 8'h02, 1, 0, 0, 3, 0));
        vecs.push_back(mk(0, 0, 8'h00, 6, 8'h02, 0, 0, 0, 3, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 8'h03, 0, 0, 0, 2, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 8'h03, 1, 0, 0, 2, 0));
        vecs.push_back(mk(0, 0, 8'h00, 6, 8'h03, 0, 0, 0, 2, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 8'h04, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 8'h04, 1, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 8'h00, 6, 8'h04, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 8'h05, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 8'h05, 1, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 6, 8'h05, 0, 0, 1, 0, 0));
        // Reset in WAIT with three bytes queued discards them.
        vecs.push_back(mk(0, 1, 8'h11, 1, 8'h05, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 8'h22, 1, 8'h11, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 8'h33, 1, 8'h11, 1, 0, 0, 2, 0));
        vecs.push_back(mk(0, 1, 8'h44, 1, 8'h11, 0, 0, 0, 3, 0));
        vecs.push_back(mk(1, 0, 8'h00, 1, 8'h00, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 10, 8'h00, 0, 0, 1, 0, 0));
        // Reset together with a write on a full FIFO: nothing stored, no overflow.
        vecs.push_back(mk(0, 1, 8'hA1, 1, 8'h00, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 8'hA2, 1, 8'hA1, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 8'hA3, 1, 8'hA1, 1, 0, 0, 2, 0));
        vecs.push_back(mk(0, 1, 8'hA4, 1, 8'hA1, 0, 0, 0, 3, 0));
        vecs.push_back(mk(0, 1, 8'hA5, 1, 8'hA1, 0, 1, 0, 4, 0));
        vecs.push_back(mk(1, 1, 8'hA6, 1, 8'h00, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 4, 8'h00, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 8'h5A, 1, 8'h00, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 8'h5A, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 8'h5A, 1, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 8, 8'h5A, 0, 0, 1, 0, 0));

        $display("[TB] applying %0d table rows", vecs.size());
        for (int i = 0; i < vecs.size(); i++) begin
            for (int r = 0; r < vecs[i].reps; r++) begin
                apply_stimulus(vecs[i].rst, vecs[i].wr_en, vecs[i].wr_d);
                check_output(i, r, vecs[i]);
            end
        end

        // Three four-byte bursts move the pointers through several wraps.
        for (int b = 0; b < 3; b++) begin
            mon_base = 8'h30 + 8'(b * 16);
            mon_idx  = 0;
            mon_cyc  = 0;
            mon_last = 0;
            mon_on   = 1'b1;
            for (int k = 0; k < 4; k++) apply_stimulus(1'b0, 1'b1, mon_base + 8'(k));
            for (int k = 0; k < 40; k++) apply_stimulus(1'b0, 1'b0, 8'h00);
            mon_on = 1'b0;
            checks++;
            if (mon_idx != 4) begin
                errors++;
                $display("[TB] FAIL burst%0d_bytes_sent: got %0d, want 4", b, mon_idx);
            end
            checks++;
            if (bus.empty !== 1'b1 || bus.count !== 3'd0) begin
                errors++;
                $display("[TB] FAIL burst%0d_drained: got empty=%b count=%0d, want empty=1 count=0", b, bus.empty, bus.count);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
